rca_4bit: RTL and testbench

- 4-bit ripple-carry adder. Sum and carry-out are captured in an output register.
- Built as a chain of WIDTH one-bit full-adder cells; the carry ripples from bit 0 to bit WIDTH-1.
- Used as a registered arithmetic leaf inside datapaths that need an unsigned sum plus signed-overflow and zero status.

---
 rtl/rca_4bit.sv | 75 +++++++
 tb/tb_rca_4bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rca_4bit.sv
// Registered WIDTH-bit ripple-carry adder with carry-out, signed-overflow and zero flags.
// One-cycle latency, one result per cycle; no backpressure, the consumer must take each result when out_valid is high.

module rca_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ c_i;
   assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module rca_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic [WIDTH:0]   sum1,
   output logic             out_valid,
   output logic             ovf,
   output logic             zero
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] s_bits;
   logic [WIDTH:0]   sum_d, sum_q;
   logic             ovf_d, ovf_q;
   logic             zero_d, zero_q;
   logic             vld_q;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      rca_fa u_fa (
         .a_i  (A[i]),
         .b_i  (B[i]),
         .c_i  (carry[i]),
         .s_o  (s_bits[i]),
         .co_o (carry[i+1])
      );
   end

   // Signed overflow is the disagreement between the carries into and out of the sign bit.
   assign sum_d  = {carry[WIDTH], s_bits};
   assign ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
   assign zero_d = ~|sum_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b1;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= in_valid;
         if (in_valid) begin
            sum_q  <= sum_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
         end
      end
   end

   assign sum1      = sum_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign out_valid = vld_q;

endmodule

// File: tb/tb_rca_4bit.sv
// Scoreboard bench for rca_4bit: stimulus queues expected outputs, a monitor pops and compares each cycle.
module tb_rca_4bit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] A, B;
   logic       cin;
   logic [4:0] sum1;
   logic       out_valid, ovf, zero;

   always #5 clk = ~clk;

   rca_4bit #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .cin       (cin),
      .sum1      (sum1),
      .out_valid (out_valid),
      .ovf       (ovf),
      .zero      (zero)
   );

   typedef struct packed {
      logic       vld;
      logic [4:0] sum;
      logic       ovf;
      logic       zero;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   logic [4:0] held_sum  = 5'd0;
   logic       held_ovf  = 1'b0;
   logic       held_zero = 1'b1;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       c;
      logic [4:0] s;
      logic       o;
   } vec_t;

   // Hand-computed: sum and signed overflow of a+b+c.
   vec_t dir_vecs[14] = '{
      '{4'd1,  4'd2,  1'b0, 5'd3,  1'b0},
      '{4'd4,  4'd5,  1'b0, 5'd9,  1'b1},
      '{4'd12, 4'd3,  1'b0, 5'd15, 1'b0},
      '{4'd14, 4'd13, 1'b0, 5'd27, 1'b0},
      '{4'd15, 4'd7,  1'b0, 5'd22, 1'b0},
      '{4'd15, 4'd15, 1'b0, 5'd30, 1'b0},
      '{4'd13, 4'd7,  1'b0, 5'd20, 1'b0},
      '{4'd8,  4'd15, 1'b0, 5'd23, 1'b1},
      '{4'd9,  4'd15, 1'b0, 5'd24, 1'b0},
      '{4'd15, 4'd9,  1'b0, 5'd24, 1'b0},
      '{4'd15, 4'd15, 1'b1, 5'd31, 1'b0},
      '{4'd7,  4'd1,  1'b0, 5'd8,  1'b1},
      '{4'd8,  4'd8,  1'b0, 5'd16, 1'b1},
      '{4'd15, 4'd1,  1'b0, 5'd16, 1'b0}
   };

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic apply(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [4:0] es, input logic eo);
      exp_t e;
      @(negedge clk);
      in_valid = v;
      A        = a;
      B        = b;
      cin      = c;
      if (v) begin
         held_sum  = es;
         held_ovf  = eo;
         held_zero = (es == 5'd0);
      end
      e.vld  = v;
      e.sum  = held_sum;
      e.ovf  = held_ovf;
      e.zero = held_zero;
      q.push_back(e);
   endtask

   // Monitor: an entry pushed at a falling edge is checked just after the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_valid", 32'(out_valid), 32'(e.vld));
            chk("sum1",      32'(sum1),      32'(e.sum));
            chk("ovf",       32'(ovf),       32'(e.ovf));
            chk("zero",      32'(zero),      32'(e.zero));
         end
      end
   end

   initial begin
      int sa, sb, ss;
      logic [4:0] es;
      logic       eo;

      rst_n    = 1'b1;
      in_valid = 1'b0;
      A        = 4'd0;
      B        = 4'd0;
      cin      = 1'b0;
      #2;
      // Inputs during reset must be discarded.
      in_valid = 1'b1;
      A        = 4'd15;
      B        = 4'd15;
      rst_n    = 1'b0;
      #1;
      chk("rst_async_valid", 32'(out_valid), 32'd0);
      chk("rst_async_sum",   32'(sum1),      32'd0);
      chk("rst_async_zero",  32'(zero),      32'd1);
      chk("rst_async_ovf",   32'(ovf),       32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold_valid", 32'(out_valid), 32'd0);
      chk("rst_hold_sum",   32'(sum1),      32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      apply(1'b1, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0);
      foreach (dir_vecs[i])
         apply(1'b1, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].c, dir_vecs[i].s, dir_vecs[i].o);

      // in_valid 1,0,1: the idle cycle must hold 3+4.
      apply(1'b1, 4'd3, 4'd4, 1'b0, 5'd7, 1'b0);
      apply(1'b0, 4'd9, 4'd9, 1'b0, 5'd18, 1'b1);
      apply(1'b1, 4'd2, 4'd2, 1'b0, 5'd4, 1'b0);

      // Mid-stream asynchronous reset, away from any clock edge.
      apply(1'b1, 4'd5, 4'd5, 1'b0, 5'd10, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum",   32'(sum1),      32'd0);
      chk("midrst_zero",  32'(zero),      32'd1);
      chk("midrst_ovf",   32'(ovf),       32'd0);
      held_sum  = 5'd0;
      held_ovf  = 1'b0;
      held_zero = 1'b1;
      rst_n     = 1'b1;

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++) begin
               es = 5'(a + b + c);
               sa = (a >= 8) ? a - 16 : a;
               sb = (b >= 8) ? b - 16 : b;
               ss = sa + sb + c;
               eo = (ss > 7) || (ss < -8);
               apply(1'b1, 4'(a), 4'(b), 1'(c), es, eo);
            end

      apply(1'b0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      #3;
      if (q.size() != 0) chk("drain", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
